// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between two byte requesters, the transmit scheduler and the UART tx core.
// The slave modport is the scheduler's view; master is the surrounding system.
interface uart_tx_sched_if #(
  parameter int DEPTH = 4
) ();
  logic                   en;
  logic                   s0_valid;
  logic [7:0]             s0_data;
  logic                   s0_ready;
  logic                   s1_valid;
  logic [7:0]             s1_data;
  logic                   s1_ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_busy;
  logic                   grant_id;
  logic                   sched_busy;
  logic [$clog2(DEPTH):0] s0_level;
  logic [$clog2(DEPTH):0] s1_level;

  modport slave (
    input  en, s0_valid, s0_data, s1_valid, s1_data, tx_busy,
    output s0_ready, s1_ready, tx_start, tx_data, grant_id, sched_busy,
           s0_level, s1_level
  );

  modport master (
    output en, s0_valid, s0_data, s1_valid, s1_data, tx_busy,
    input  s0_ready, s1_ready, tx_start, tx_data, grant_id, sched_busy,
           s0_level, s1_level
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin transmit scheduler in front of the UART tx core.
// Each requester owns a circular FIFO; frames are sequenced from the core's busy flag.
module uart_tx_sched #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem0 [DEPTH];
  logic [7:0]    mem1 [DEPTH];
  logic [AW-1:0] wr_ptr0;
  logic [AW-1:0] rd_ptr0;
  logic [AW-1:0] wr_ptr1;
  logic [AW-1:0] rd_ptr1;
  logic [LW-1:0] count0;
  logic [LW-1:0] count1;
  logic          full0;
  logic          full1;
  logic          empty0;
  logic          empty1;
  logic          push0;
  logic          push1;
  logic          pop0;
  logic          pop1;
  logic          grant;
  logic          sel;
  logic          last;
  logic          tx_start;
  logic [7:0]    tx_data_q;
  logic          grant_id_q;

  assign full0  = (count0 == LW'(DEPTH));
  assign full1  = (count1 == LW'(DEPTH));
  assign empty0 = (count0 == '0);
  assign empty1 = (count1 == '0);

  // Ready reflects only fullness, so a pop in the same cycle never frees the slot early.
  assign push0 = bus.s0_valid && !full0;
  assign push1 = bus.s1_valid && !full1;
  assign pop0  = grant && !sel;
  assign pop1  = grant && sel;

  always_ff @(posedge clk) begin
    if (push0) mem0[wr_ptr0] <= bus.s0_data;
    if (push1) mem1[wr_ptr1] <= bus.s1_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr0 <= '0;
      rd_ptr0 <= '0;
      count0  <= '0;
    end else begin
      if (push0) wr_ptr0 <= wr_ptr0 + AW'(1);
      if (pop0)  rd_ptr0 <= rd_ptr0 + AW'(1);
      case ({push0, pop0})
        2'b10:   count0 <= count0 + LW'(1);
        2'b01:   count0 <= count0 - LW'(1);
        default: count0 <= count0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr1 <= '0;
      rd_ptr1 <= '0;
      count1  <= '0;
    end else begin
      if (push1) wr_ptr1 <= wr_ptr1 + AW'(1);
      if (pop1)  rd_ptr1 <= rd_ptr1 + AW'(1);
      case ({push1, pop1})
        2'b10:   count1 <= count1 + LW'(1);
        2'b01:   count1 <= count1 - LW'(1);
        default: count1 <= count1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // On a tie the requester opposite the last winner is chosen; en only matters in ARB.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    sel       = 1'b0;
    tx_start  = 1'b0;
    if (!empty0 && !empty1) sel = ~last;
    else                    sel = empty0;
    case (state)
      ARB: begin
        if (bus.en && !(empty0 && empty1)) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= 8'h00;
      grant_id_q <= 1'b0;
      last       <= 1'b1;
    end else if (grant) begin
      tx_data_q  <= sel ? mem1[rd_ptr1] : mem0[rd_ptr0];
      grant_id_q <= sel;
      last       <= sel;
    end
  end

  assign bus.s0_ready   = !full0;
  assign bus.s1_ready   = !full1;
  assign bus.s0_level   = count0;
  assign bus.s1_level   = count1;
  assign bus.tx_start   = tx_start;
  assign bus.tx_data    = tx_data_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.sched_busy = (state != ARB);
endmodule
